fc_layer_seq: RTL and testbench
===============================

Name: fc_layer_seq

Overview:
- Parametrised, time-multiplexed fully connected layer computing out[o] = sat(((bias[o] + sum_i x[i]*w[o*N_IN+i]) >>> SHIFT)) for o = 0..N_OUT-1.
- Uses a single signed MAC and valid/ready handshakes on input and output.
- Successor to the combinational 10x10 neural_net layer, which had no handshakes, saturation or requantization.
- Sits between activation producers and the next layer; layers chain directly via out_valid/out_ready -> in_valid/in_ready.

Parameters:
- N_IN, 10, number of input activations.
- N_OUT, 10, number of neurons (outputs).
- DW, 8, width of activations, weights, biases and outputs; signed two's complement.
- ACC_W, 24, accumulator width; must be >= 2*DW + clog2(N_IN) + 1.
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data.
- in_data  in  N_IN*DW  activation x[k] at bits [k*DW +: DW].
- weights  in  N_OUT*N_IN*DW  w[k] at bits [k*DW +: DW], k = o*N_IN + i.
- biases  in  N_OUT*DW  bias[o] at bits [o*DW +: DW].
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  N_OUT*DW  result y[o] at bits [o*DW +: DW].
- busy  out  1  high in COMPUTE or DONE.

Behaviour:
- Clock and reset are fixed: one clock, clk. Reset, reset, is synchronous and active-high.
- Reset values:
  - State = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - out_data = 0, all counters = 0, accumulator = 0.
- Reset asserted mid-COMPUTE or mid-DONE aborts the operation. The next cycle shows the reset values, and the partial result is discarded.
- FSM IDLE -> COMPUTE -> DONE -> IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: register all of in_data into an internal x array, clear i/o counters, load acc = sign-extended bias[0], go to COMPUTE.
- COMPUTE:
  - in_ready = 0.
  - One MAC per cycle: acc_next = acc + x[i]*w[o*N_IN+i]. The product is 2*DW signed and sign-extended to ACC_W.
  - When i == N_IN-1:
    - y[o] = sat(acc_next >>> SHIFT), written to the out_data register.
    - acc is reloaded with sign-extended bias[o+1].
    - i = 0, o increments.
  - Otherwise i increments.
  - After the final MAC (o == N_OUT-1, i == N_IN-1), go to DONE.
- Saturation: the shifted value is clamped to [-2^(DW-1), 2^(DW-1)-1]. The bias is added at accumulator scale (before the shift).
- Latency: out_valid rises exactly N_OUT*N_IN cycles after the accepting edge (100 cycles by default).
- DONE:
  - out_valid = 1.
  - out_data is held stable until out_valid && out_ready; then go to IDLE, where in_ready = 1 the following cycle.
  - out_ready low holds DONE indefinitely.
  - in_valid is ignored while not in IDLE; no overlap, no input buffering.
- weights and biases are not captured. They are configuration and must be held stable from acceptance until out_valid; changing them mid-COMPUTE gives undefined results.
- out_data retains the last result in IDLE. It is only updated per neuron during COMPUTE.
- N_IN = 1 or N_OUT = 1 must work: the counter wraps and the terminal condition coincide.

Optional Feature:
- Macro FC_RELU_EN.
- When defined, each y[o] passes through ReLU after saturation: negative results are written as 0. Latency is unchanged.
- When undefined, signed saturated results are output unchanged.

Test Plan:
- Defaults, SHIFT=0, all x=1, all w=1, all bias=0, out_ready=1:
  - out_valid exactly 100 cycles after acceptance.
  - Every y = 10.
  - Then in_ready=1 the following cycle.
- x=2, w=-3, bias=5:
  - Every y = -55 without FC_RELU_EN.
  - Every y = 0 with FC_RELU_EN.
- Saturation:
  - x=127, w=127, bias=0 -> every y = 127.
  - x=-128, w=127 -> every y = -128 (0 with FC_RELU_EN).
- SHIFT=4, x=1, w=16, bias=0 -> every y = 10.
- Second check at N_IN=1, N_OUT=1: x=3, w=4, bias=1 -> y = 13, out_valid 1 cycle after acceptance.
- Backpressure: out_ready=0 for 20 cycles after out_valid rises:
  - out_valid stays 1, out_data is stable and in_ready=0.
  - A pulsed in_valid is ignored.
  - Then out_ready=1 -> IDLE next cycle.
- Reset asserted for 1 cycle at cycle 50 of COMPUTE:
  - Next cycle: out_valid=0, in_ready=1, busy=0, out_data=0.
  - A new transaction then completes with correct values after 100 cycles.

Source files
------------

// File: rtl/fc_layer_seq.sv
// fc_layer_seq: time-multiplexed fully connected layer built on one signed MAC,
// with requantizing arithmetic shift and saturation. Optional ReLU stage: define FC_RELU_EN.
module fc_layer_seq #(
  parameter int N_IN  = 10,
  parameter int N_OUT = 10,
  parameter int DW    = 8,
  parameter int ACC_W = 24,
  parameter int SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*DW-1:0]       in_data,
  input  logic [N_OUT*N_IN*DW-1:0] weights,
  input  logic [N_OUT*DW-1:0]      biases,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_OUT*DW-1:0]      out_data,
  output logic                     busy
);

  localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t                  state, state_next;
  logic [N_IN*DW-1:0]      x_q;
  logic [IW-1:0]           i_cnt;
  logic [OW-1:0]           o_cnt;
  logic signed [ACC_W-1:0] acc, acc_next, acc_sh, bias_ld;
  logic signed [DW-1:0]    x_cur, w_cur, bias_sel, y_sat, y_out;
  logic signed [2*DW-1:0]  prod;
  logic [N_OUT*DW-1:0]     out_q;
  logic                    i_last, o_last;
  int                      b_idx;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A transfer occurs on a rising edge where valid && ready are both high;
  // in_ready and out_valid depend only on state, never combinationally on the peer.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (i_last && o_last) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    i_last   = (i_cnt == IW'(N_IN - 1));
    o_last   = (o_cnt == OW'(N_OUT - 1));
    x_cur    = x_q[int'(i_cnt)*DW +: DW];
    w_cur    = weights[(int'(o_cnt)*N_IN + int'(i_cnt))*DW +: DW];
    prod     = x_cur * w_cur;
    acc_next = acc + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    acc_sh   = acc_next >>> SHIFT;
    // Bias is folded in at accumulator scale; after the last neuron nothing is reloaded.
    b_idx    = (state == COMPUTE && !o_last) ? int'(o_cnt) + 1 : 0;
    bias_sel = biases[b_idx*DW +: DW];
    bias_ld  = (state == COMPUTE && o_last) ? '0 : {{(ACC_W-DW){bias_sel[DW-1]}}, bias_sel};
    if (acc_sh > SAT_MAX)      y_sat = SAT_MAX[DW-1:0];
    else if (acc_sh < SAT_MIN) y_sat = SAT_MIN[DW-1:0];
    else                       y_sat = acc_sh[DW-1:0];
`ifdef FC_RELU_EN
    y_out = y_sat[DW-1] ? '0 : y_sat;
`else
    y_out = y_sat;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q   <= '0;
      i_cnt <= '0;
      o_cnt <= '0;
      acc   <= '0;
      out_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q   <= in_data;
            i_cnt <= '0;
            o_cnt <= '0;
            acc   <= bias_ld;
          end
        end
        COMPUTE: begin
          if (i_last) begin
            out_q[int'(o_cnt)*DW +: DW] <= y_out;
            acc   <= bias_ld;
            i_cnt <= '0;
            o_cnt <= o_last ? '0 : o_cnt + 1'b1;
          end else begin
            acc   <= acc_next;
            i_cnt <= i_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = out_q;

endmodule

// File: tb/tb_fc_layer_seq.sv
// Scoreboard bench for fc_layer_seq: default 10x10 instance, a SHIFT=4 instance
// and a 1x1 instance; expected vectors are queued at issue and checked by monitors.
module tb_fc_layer_seq;

  localparam int N_IN  = 10;
  localparam int N_OUT = 10;
  localparam int DW    = 8;
  localparam int VW    = N_OUT * DW;
  localparam int WW    = N_OUT * N_IN * DW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // default instance
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [VW-1:0] in_data, biases, out_data;
  logic [WW-1:0] weights;

  // SHIFT=4 instance
  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [VW-1:0] s_in_data, s_biases, s_out_data;
  logic [WW-1:0] s_weights;

  // 1x1 instance
  logic          n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_busy;
  logic [DW-1:0] n_in_data, n_weights, n_biases, n_out_data;

  fc_layer_seq u_main (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .weights(weights), .biases(biases), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  fc_layer_seq #(.SHIFT(4)) u_shift (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .weights(s_weights), .biases(s_biases), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .busy(s_busy)
  );

  fc_layer_seq #(.N_IN(1), .N_OUT(1)) u_small (
    .clk(clk), .reset(reset), .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .weights(n_weights), .biases(n_biases), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out_data(n_out_data), .busy(n_busy)
  );

  // scoreboard
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] exp_s_q[$];
  logic [DW-1:0] exp_n_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: output with empty expected queue", name);
  endtask

  function automatic int ry(input int v);
`ifdef FC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [VW-1:0] rep_v(input int v);
    logic [VW-1:0] r;
    for (int k = 0; k < N_OUT; k++) r[k*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [WW-1:0] rep_w(input int v);
    logic [WW-1:0] r;
    for (int k = 0; k < N_OUT*N_IN; k++) r[k*DW +: DW] = DW'(v);
    return r;
  endfunction

  // monitors
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) unexpected("main out");
      else chk("main out_data", out_data, exp_q.pop_front());
    end
    if (!reset && s_out_valid && s_out_ready) begin
      if (exp_s_q.size() == 0) unexpected("shift out");
      else chk("shift out_data", s_out_data, exp_s_q.pop_front());
    end
    if (!reset && n_out_valid && n_out_ready) begin
      if (exp_n_q.size() == 0) unexpected("small out");
      else chk("small out_data", VW'(n_out_data), VW'(exp_n_q.pop_front()));
    end
  end

  // driver tasks for the default instance
  task automatic start_main(input int x, input int w, input logic [VW-1:0] bv,
                            input logic push, input logic [VW-1:0] expv);
    chk("main in_ready before accept", in_ready, 1);
    in_data  = rep_v(x);
    weights  = rep_w(w);
    biases   = bv;
    if (push) exp_q.push_back(expv);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_main(input string name, input int exp_lat);
    int lat = 0;
    chk({name, " busy in compute"}, busy, 1);
    chk({name, " in_ready in compute"}, in_ready, 0);
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, lat, exp_lat);
  endtask

  task automatic finish_main(input string name);
    @(posedge clk); #1;
    chk({name, " in_ready after handshake"}, in_ready, 1);
    chk({name, " out_valid after handshake"}, out_valid, 0);
  endtask

  logic [VW-1:0] bv, ev;
  int lat;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; in_data = '0; weights = '0; biases = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_in_data = '0; s_weights = '0; s_biases = '0;
    n_in_valid = 1'b0; n_out_ready = 1'b1; n_in_data = '0; n_weights = '0; n_biases = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset out_data", out_data, '0);

    // all ones: every y = 10
    start_main(1, 1, rep_v(0), 1'b1, rep_v(10));
    wait_main("ones", 100);
    finish_main("ones");

    // 5 + 10*(2*-3) = -55
    start_main(2, -3, rep_v(5), 1'b1, rep_v(ry(-55)));
    wait_main("neg", 100);
    finish_main("neg");

    // positive saturation
    start_main(127, 127, rep_v(0), 1'b1, rep_v(127));
    wait_main("satpos", 100);
    finish_main("satpos");

    // negative saturation
    start_main(-128, 127, rep_v(0), 1'b1, rep_v(ry(-128)));
    wait_main("satneg", 100);
    finish_main("satneg");

    // per-neuron bias: y[o] = 10 + (10*o - 40)
    for (int k = 0; k < N_OUT; k++) begin
      bv[k*DW +: DW] = DW'(10*k - 40);
      ev[k*DW +: DW] = DW'(ry(10*k - 30));
    end
    start_main(1, 1, bv, 1'b1, ev);
    wait_main("bias", 100);
    finish_main("bias");

    // backpressure: 20*1 - 3 = 17, held while out_ready is low
    out_ready = 1'b0;
    start_main(1, 2, rep_v(-3), 1'b1, rep_v(17));
    wait_main("bp", 100);
    for (int c = 0; c < 20; c++) begin
      chk("bp out_valid held", out_valid, 1);
      chk("bp in_ready low", in_ready, 0);
      chk("bp out_data stable", out_data, rep_v(17));
      in_valid = (c == 5);
      if (c == 5) in_data = rep_v(9);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    finish_main("bp");
    repeat (3) @(posedge clk);
    #1;
    chk("bp pulse ignored busy", busy, 0);
    chk("bp pulse ignored out_valid", out_valid, 0);

    // reset abort mid-compute
    start_main(1, 1, rep_v(0), 1'b0, '0);
    repeat (50) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort out_valid", out_valid, 0);
    chk("abort in_ready", in_ready, 1);
    chk("abort busy", busy, 0);
    chk("abort out_data", out_data, '0);
    // 100 + 10*(3*-1) = 70
    start_main(3, -1, rep_v(100), 1'b1, rep_v(70));
    wait_main("after abort", 100);
    finish_main("after abort");

    // SHIFT=4: 160 >>> 4 = 10
    s_in_data = rep_v(1); s_weights = rep_w(16); s_biases = rep_v(0);
    exp_s_q.push_back(rep_v(10));
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 400) begin @(posedge clk); #1; lat++; end
    chk("shift latency", lat, 100);
    @(posedge clk); #1;
    // (-160 - 8) >>> 4 = -11 (floor)
    s_in_data = rep_v(-1); s_biases = rep_v(-8);
    exp_s_q.push_back(rep_v(ry(-11)));
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 400) begin @(posedge clk); #1; lat++; end
    chk("shift neg latency", lat, 100);
    @(posedge clk); #1;
    chk("shift in_ready after", s_in_ready, 1);

    // 1x1: 1 + 3*4 = 13, one cycle latency
    n_in_data = 8'd3; n_weights = 8'd4; n_biases = 8'd1;
    exp_n_q.push_back(8'd13);
    n_in_valid = 1'b1;
    @(posedge clk); #1;
    n_in_valid = 1'b0;
    lat = 0;
    while (!n_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("small latency", lat, 1);
    @(posedge clk); #1;
    chk("small in_ready after", n_in_ready, 1);
    // 2 + (-5*7) = -33
    n_in_data = -8'sd5; n_weights = 8'd7; n_biases = 8'd2;
    exp_n_q.push_back(DW'(ry(-33)));
    n_in_valid = 1'b1;
    @(posedge clk); #1;
    n_in_valid = 1'b0;
    lat = 0;
    while (!n_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("small neg latency", lat, 1);
    repeat (3) @(posedge clk);
    #1;

    chk("main queue drained", exp_q.size(), 0);
    chk("shift queue drained", exp_s_q.size(), 0);
    chk("small queue drained", exp_n_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
